l2_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer between the two L2 caches and the shared, single-ported main memory. It accepts read/write requests from each cache, range-checks the block address, and grants the memory to one requester at a time with round-robin fairness. It then runs the memory handshake and returns read data, completion, and invalid-address status to the owning cache.

---
 rtl/l2_mem_pkg.sv | 23 ++
 rtl/l2_mem_arbiter_rr_arb2.sv | 41 ++++
 rtl/l2_mem_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_l2_mem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_mem_pkg.sv
// Shared sizing defaults, port identifiers and FSM state type for l2_mem_arbiter.
package l2_mem_pkg;

  localparam int L2_INDEX_BITS     = 7;
  localparam int L2_TAG_BITS       = 24;
  localparam int L2_NO_OF_SETS     = 1950;
  localparam int L2_BLOCK_SIZE     = 512;
  localparam int L2_TIMEOUT_CYCLES = 64;
  localparam int ADDR_W            = L2_TAG_BITS + L2_INDEX_BITS;

  // Grant encoding shared by the arbiter and the sequencer.
  localparam logic PORT_1 = 1'b0;
  localparam logic PORT_2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/l2_mem_arbiter_rr_arb2.sv
// Two-requester round-robin grant: a tie goes to the port that did not win last time.
module rr_arb2
  import l2_mem_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic req_1,
  input  logic req_2,
  input  logic upd_en,
  input  logic upd_port,
  output logic gnt_valid,
  output logic gnt_port
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_valid    = req_1 | req_2;
    gnt_port     = PORT_1;
    last_grant_d = last_grant_q;
    if (req_1 && req_2) begin
      gnt_port = ~last_grant_q;
    end else if (req_2) begin
      gnt_port = PORT_2;
    end
    if (upd_en) begin
      last_grant_d = upd_port;
    end
  end

  // Port 2 is the reset owner so that port 1 wins the first tie.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      last_grant_q <= PORT_2;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Arbiter/sequencer between two L2 caches and one single-ported main memory.
// Define ARB_TIMEOUT_EN to abort a memory access that waits TIMEOUT_CYCLES without mem_ack.
module l2_mem_arbiter
  import l2_mem_pkg::*;
#(
  parameter int INDEX_BITS     = L2_INDEX_BITS,
  parameter int TAG_BITS       = L2_TAG_BITS,
  parameter int NO_OF_SETS     = L2_NO_OF_SETS,
  parameter int BLOCK_SIZE     = L2_BLOCK_SIZE,
  parameter int TIMEOUT_CYCLES = L2_TIMEOUT_CYCLES
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           rd_1,
  input  logic                           wr_1,
  input  logic [TAG_BITS-1:0]            tag_1,
  input  logic [INDEX_BITS-1:0]          index_1,
  input  logic [BLOCK_SIZE-1:0]          wdata_1,
  input  logic                           rd_2,
  input  logic                           wr_2,
  input  logic [TAG_BITS-1:0]            tag_2,
  input  logic [INDEX_BITS-1:0]          index_2,
  input  logic [BLOCK_SIZE-1:0]          wdata_2,
  output logic                           done_1,
  output logic                           done_2,
  output logic [BLOCK_SIZE-1:0]          rdata_1,
  output logic [BLOCK_SIZE-1:0]          rdata_2,
  output logic                           invalid_1,
  output logic                           invalid_2,
  output logic                           timeout_1,
  output logic                           timeout_2,
  output logic                           mem_rd,
  output logic                           mem_wr,
  output logic [TAG_BITS+INDEX_BITS-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0]          mem_wdata,
  input  logic [BLOCK_SIZE-1:0]          mem_rdata,
  input  logic                           mem_ack
);

  localparam int AW = TAG_BITS + INDEX_BITS;

  arb_state_t            state_q, state_d;
  logic                  g_q, g_d;
  logic                  wr_q, wr_d;
  logic                  inv_q, inv_d;
  logic                  tmo_q, tmo_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
  logic [BLOCK_SIZE-1:0] rbuf_q, rbuf_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  done_1_q, done_1_d;
  logic                  done_2_q, done_2_d;
  logic                  invalid_1_q, invalid_1_d;
  logic                  invalid_2_q, invalid_2_d;
  logic                  timeout_1_q, timeout_1_d;
  logic                  timeout_2_q, timeout_2_d;
  logic [BLOCK_SIZE-1:0] rdata_1_q, rdata_1_d;
  logic [BLOCK_SIZE-1:0] rdata_2_q, rdata_2_d;

  logic gnt_valid;
  logic gnt_port;
  logic arb_upd;
  logic tmo_hit;

  rr_arb2 u_arb (
    .CLK       (CLK),
    .RST       (RST),
    .req_1     (rd_1 | wr_1),
    .req_2     (rd_2 | wr_2),
    .upd_en    (arb_upd),
    .upd_port  (g_q),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT && !mem_ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the WAIT cycle in which the counter would reach TIMEOUT_CYCLES.
  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    wr_d        = wr_q;
    inv_d       = inv_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    done_1_d    = 1'b0;
    done_2_d    = 1'b0;
    invalid_1_d = 1'b0;
    invalid_2_d = 1'b0;
    timeout_1_d = 1'b0;
    timeout_2_d = 1'b0;
    rdata_1_d   = '0;
    rdata_2_d   = '0;
    arb_upd     = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          g_d     = gnt_port;
          // A simultaneous rd and wr is a write.
          wr_d    = (gnt_port == PORT_2) ? wr_2 : wr_1;
          addr_d  = (gnt_port == PORT_2) ? {tag_2, index_2} : {tag_1, index_1};
          wdata_d = (gnt_port == PORT_2) ? wdata_2 : wdata_1;
          inv_d   = 1'b0;
          tmo_d   = 1'b0;
          rbuf_d  = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (addr_q >= AW'(NO_OF_SETS)) begin
          inv_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd_d = ~wr_q;
        mem_wr_d = wr_q;
        state_d  = WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          if (!wr_q) begin
            rbuf_d = mem_rdata;
          end
          state_d = RESP;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // rbuf_q is still zero for writes, invalid addresses and timeouts.
        done_1_d    = (g_q == PORT_1);
        done_2_d    = (g_q == PORT_2);
        invalid_1_d = inv_q && (g_q == PORT_1);
        invalid_2_d = inv_q && (g_q == PORT_2);
        timeout_1_d = tmo_q && (g_q == PORT_1);
        timeout_2_d = tmo_q && (g_q == PORT_2);
        rdata_1_d   = (g_q == PORT_1) ? rbuf_q : '0;
        rdata_2_d   = (g_q == PORT_2) ? rbuf_q : '0;
        arb_upd     = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      g_q         <= PORT_1;
      wr_q        <= 1'b0;
      inv_q       <= 1'b0;
      tmo_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      done_1_q    <= 1'b0;
      done_2_q    <= 1'b0;
      invalid_1_q <= 1'b0;
      invalid_2_q <= 1'b0;
      timeout_1_q <= 1'b0;
      timeout_2_q <= 1'b0;
      rdata_1_q   <= '0;
      rdata_2_q   <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      wr_q        <= wr_d;
      inv_q       <= inv_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      done_1_q    <= done_1_d;
      done_2_q    <= done_2_d;
      invalid_1_q <= invalid_1_d;
      invalid_2_q <= invalid_2_d;
      timeout_1_q <= timeout_1_d;
      timeout_2_q <= timeout_2_d;
      rdata_1_q   <= rdata_1_d;
      rdata_2_q   <= rdata_2_d;
    end
  end

  assign done_1    = done_1_q;
  assign done_2    = done_2_q;
  assign rdata_1   = rdata_1_q;
  assign rdata_2   = rdata_2_q;
  assign invalid_1 = invalid_1_q;
  assign invalid_2 = invalid_2_q;
  assign timeout_1 = timeout_1_q;
  assign timeout_2 = timeout_2_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Scoreboard bench for l2_mem_arbiter: tasks push expected strobes/completions, a monitor pops and compares.
module tb_l2_mem_arbiter;
  import l2_mem_pkg::*;

  localparam int TMO = 64;

  logic         CLK = 1'b0;
  logic         RST;
  logic         rd_1, wr_1, rd_2, wr_2;
  logic [23:0]  tag_1, tag_2;
  logic [6:0]   index_1, index_2;
  logic [511:0] wdata_1, wdata_2;
  logic         done_1, done_2;
  logic [511:0] rdata_1, rdata_2;
  logic         invalid_1, invalid_2, timeout_1, timeout_2;
  logic         mem_rd, mem_wr;
  logic [30:0]  mem_addr;
  logic [511:0] mem_wdata;
  logic [511:0] mem_rdata;
  logic         mem_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int           mem_lat = 1;
  bit           mem_mute = 1'b0;
  bit           use_fixed = 1'b0;
  logic [511:0] mem_fixed = '0;

  typedef struct {
    int           cyc;
    int           port;
    logic [511:0] rdata;
    bit           inv;
    bit           tmo;
  } exp_done_t;

  typedef struct {
    int           cyc;
    bit           wr;
    logic [30:0]  addr;
    logic [511:0] wdata;
    bit           chk_wd;
  } exp_mem_t;

  exp_done_t exp_done_q[$];
  exp_mem_t  exp_mem_q[$];

  l2_mem_arbiter #(
    .INDEX_BITS(7), .TAG_BITS(24), .NO_OF_SETS(1950), .BLOCK_SIZE(512), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .rd_1(rd_1), .wr_1(wr_1), .tag_1(tag_1), .index_1(index_1), .wdata_1(wdata_1),
    .rd_2(rd_2), .wr_2(wr_2), .tag_2(tag_2), .index_2(index_2), .wdata_2(wdata_2),
    .done_1(done_1), .done_2(done_2), .rdata_1(rdata_1), .rdata_2(rdata_2),
    .invalid_1(invalid_1), .invalid_2(invalid_2), .timeout_1(timeout_1), .timeout_2(timeout_2),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [511:0] mem_fn(input logic [30:0] a);
    return {16{32'(a) ^ 32'h3C00_0000}};
  endfunction

  // Memory model: acks mem_lat cycles after each strobe unless muted.
  initial begin
    logic [30:0] a;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge CLK);
      if ((mem_rd || mem_wr) && !mem_mute) begin
        a = mem_addr;
        repeat (mem_lat - 1) @(negedge CLK);
        mem_ack   = 1'b1;
        mem_rdata = use_fixed ? mem_fixed : mem_fn(a);
        @(negedge CLK);
        mem_ack   = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic monitor();
    exp_done_t    e;
    exp_mem_t     m;
    int           port;
    logic [511:0] rd;
    logic         inv, tmo;
    forever begin
      @(negedge CLK);
      if (mem_rd || mem_wr) begin
        checks++;
        if (exp_mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_strobe unexpected at cyc %0d rd %0b wr %0b addr %0d, none expected", cyc, mem_rd, mem_wr, mem_addr);
        end else begin
          m = exp_mem_q.pop_front();
          if (mem_rd === mem_wr || cyc != m.cyc || mem_wr !== m.wr || mem_addr !== m.addr ||
              (m.chk_wd && mem_wdata !== m.wdata)) begin
            errors++;
            $display("FAIL mem_strobe got cyc %0d rd %0b wr %0b addr %0d wdata[31:0] %h, expected cyc %0d wr %0b addr %0d wdata[31:0] %h",
                     cyc, mem_rd, mem_wr, mem_addr, mem_wdata[31:0], m.cyc, m.wr, m.addr, m.wdata[31:0]);
          end
        end
      end
      if (done_1 || done_2) begin
        port = done_1 ? 1 : 2;
        rd   = done_1 ? rdata_1 : rdata_2;
        inv  = done_1 ? invalid_1 : invalid_2;
        tmo  = done_1 ? timeout_1 : timeout_2;
        $display("txn port %0d cyc %0d rdata[31:0] %h invalid %0b timeout %0b", port, cyc, rd[31:0], inv, tmo);
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL done unexpected on port %0d at cyc %0d, none expected", port, cyc);
        end else begin
          e = exp_done_q.pop_front();
          if ((done_1 && done_2) || port != e.port || cyc != e.cyc || rd !== e.rdata ||
              inv !== e.inv || tmo !== e.tmo) begin
            errors++;
            $display("FAIL done got port %0d cyc %0d inv %0b tmo %0b rdata %h, expected port %0d cyc %0d inv %0b tmo %0b rdata %h",
                     port, cyc, inv, tmo, rd, e.port, e.cyc, e.inv, e.tmo, e.rdata);
          end
        end
      end
    end
  endtask

  // Waits for n completions, dropping each finished port's request unless hold is set.
  task automatic wait_dones(input int n, input bit hold, input int budget);
    int seen = 0;
    int t = 0;
    while (seen < n && t < budget) begin
      @(negedge CLK);
      t++;
      if (done_1) begin
        seen++;
        if (!hold) begin rd_1 = 1'b0; wr_1 = 1'b0; end
      end
      if (done_2) begin
        seen++;
        if (!hold) begin rd_2 = 1'b0; wr_2 = 1'b0; end
      end
    end
    rd_1 = 1'b0; wr_1 = 1'b0; rd_2 = 1'b0; wr_2 = 1'b0;
    checks++;
    if (seen < n) begin
      errors++;
      $display("FAIL wait_dones saw %0d completions within %0d cycles, expected %0d", seen, budget, n);
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_drained(input string name);
    repeat (3) @(negedge CLK);
    checks++;
    if (exp_done_q.size() != 0 || exp_mem_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending done %0d strobes %0d, expected 0 and 0", name, exp_done_q.size(), exp_mem_q.size());
      exp_done_q.delete();
      exp_mem_q.delete();
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({done_1, done_2, invalid_1, invalid_2, timeout_1, timeout_2, mem_rd, mem_wr} !== 8'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b, expected 00000000",
               {done_1, done_2, invalid_1, invalid_2, timeout_1, timeout_2, mem_rd, mem_wr});
    end
    checks++;
    if (mem_addr !== 31'd0) begin
      errors++; $display("FAIL reset_mem_addr got %h, expected 0", mem_addr);
    end
    checks++;
    if (mem_wdata !== 512'd0) begin
      errors++; $display("FAIL reset_mem_wdata got %h, expected 0", mem_wdata[31:0]);
    end
    checks++;
    if (rdata_1 !== 512'd0 || rdata_2 !== 512'd0) begin
      errors++; $display("FAIL reset_rdata got %h/%h, expected 0/0", rdata_1[31:0], rdata_2[31:0]);
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_read_p1();
    int n;
    mem_lat   = 3;
    use_fixed = 1'b1;
    mem_fixed = {64{8'hA5}};
    @(negedge CLK);
    rd_1 = 1'b1; tag_1 = 24'd0; index_1 = 7'd5;
    n = cyc + 1;
    exp_mem_q.push_back('{cyc: n + 2, wr: 1'b0, addr: 31'd5, wdata: '0, chk_wd: 1'b0});
    exp_done_q.push_back('{cyc: n + 6, port: 1, rdata: {64{8'hA5}}, inv: 1'b0, tmo: 1'b0});
    wait_dones(1, 1'b0, 40);
    use_fixed = 1'b0;
    check_drained("read_p1");
  endtask

  task automatic test_both_write();
    int n;
    pulse_reset();
    mem_lat = 1;
    @(negedge CLK);
    wr_1 = 1'b1; tag_1 = 24'd1; index_1 = 7'd3;  wdata_1 = {16{32'hDEAD_0001}};
    wr_2 = 1'b1; rd_2 = 1'b1; tag_2 = 24'd0; index_2 = 7'd100; wdata_2 = {16{32'hBEEF_0002}};
    n = cyc + 1;
    exp_mem_q.push_back('{cyc: n + 2, wr: 1'b1, addr: 31'd131, wdata: {16{32'hDEAD_0001}}, chk_wd: 1'b1});
    exp_mem_q.push_back('{cyc: n + 7, wr: 1'b1, addr: 31'd100, wdata: {16{32'hBEEF_0002}}, chk_wd: 1'b1});
    exp_done_q.push_back('{cyc: n + 4, port: 1, rdata: '0, inv: 1'b0, tmo: 1'b0});
    exp_done_q.push_back('{cyc: n + 9, port: 2, rdata: '0, inv: 1'b0, tmo: 1'b0});
    wait_dones(2, 1'b0, 60);
    check_drained("both_write");
  endtask

  task automatic test_alternate();
    int n;
    pulse_reset();
    mem_lat = 1;
    @(negedge CLK);
    rd_1 = 1'b1; tag_1 = 24'd0; index_1 = 7'd10;
    rd_2 = 1'b1; tag_2 = 24'd0; index_2 = 7'd20;
    n = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      exp_mem_q.push_back('{cyc: n + 2 + 5 * k, wr: 1'b0, addr: (k % 2 == 0) ? 31'd10 : 31'd20,
                            wdata: '0, chk_wd: 1'b0});
      exp_done_q.push_back('{cyc: n + 4 + 5 * k, port: (k % 2 == 0) ? 1 : 2,
                             rdata: mem_fn((k % 2 == 0) ? 31'd10 : 31'd20), inv: 1'b0, tmo: 1'b0});
    end
    wait_dones(4, 1'b1, 80);
    check_drained("alternate");
  endtask

  task automatic test_invalid();
    int n;
    mem_lat = 2;
    @(negedge CLK);
    rd_2 = 1'b1; tag_2 = 24'd15; index_2 = 7'd30;
    n = cyc + 1;
    exp_done_q.push_back('{cyc: n + 2, port: 2, rdata: '0, inv: 1'b1, tmo: 1'b0});
    wait_dones(1, 1'b0, 20);
    check_drained("invalid_1950");

    @(negedge CLK);
    rd_1 = 1'b1; tag_1 = 24'd15; index_1 = 7'd29;
    n = cyc + 1;
    exp_mem_q.push_back('{cyc: n + 2, wr: 1'b0, addr: 31'd1949, wdata: '0, chk_wd: 1'b0});
    exp_done_q.push_back('{cyc: n + 5, port: 1, rdata: mem_fn(31'd1949), inv: 1'b0, tmo: 1'b0});
    wait_dones(1, 1'b0, 30);
    check_drained("valid_1949");

    @(negedge CLK);
    wr_1 = 1'b1; tag_1 = 24'hFF_FFFF; index_1 = 7'h7F; wdata_1 = {16{32'h0BAD_0BAD}};
    n = cyc + 1;
    exp_done_q.push_back('{cyc: n + 2, port: 1, rdata: '0, inv: 1'b1, tmo: 1'b0});
    wait_dones(1, 1'b0, 20);
    check_drained("invalid_max");
  endtask

  task automatic test_no_abort();
    int n;
    mem_lat = 2;
    @(negedge CLK);
    wr_2 = 1'b1; tag_2 = 24'd2; index_2 = 7'd44; wdata_2 = {16{32'h1234_5678}};
    n = cyc + 1;
    exp_mem_q.push_back('{cyc: n + 2, wr: 1'b1, addr: 31'd300, wdata: {16{32'h1234_5678}}, chk_wd: 1'b1});
    exp_done_q.push_back('{cyc: n + 5, port: 2, rdata: '0, inv: 1'b0, tmo: 1'b0});
    @(negedge CLK);
    wr_2 = 1'b0;
    wait_dones(1, 1'b0, 30);
    check_drained("no_abort");
  endtask

  task automatic test_reset_mid();
    int n;
    mem_mute = 1'b1;
    @(negedge CLK);
    rd_1 = 1'b1; tag_1 = 24'd0; index_1 = 7'd42;
    n = cyc + 1;
    exp_mem_q.push_back('{cyc: n + 2, wr: 1'b0, addr: 31'd42, wdata: '0, chk_wd: 1'b0});
    while (cyc < n + 4) @(negedge CLK);
    RST  = 1'b0;
    rd_1 = 1'b0;
    @(negedge CLK);
    checks++;
    if ({done_1, done_2, mem_rd, mem_wr} !== 4'b0 || mem_addr !== 31'd0) begin
      errors++;
      $display("FAIL reset_mid got done/strobes %b addr %0d, expected 0000 addr 0",
               {done_1, done_2, mem_rd, mem_wr}, mem_addr);
    end
    @(negedge CLK);
    RST = 1'b1;
    repeat (8) @(negedge CLK);
    mem_mute = 1'b0;
    mem_lat  = 2;
    rd_1 = 1'b1; tag_1 = 24'd0; index_1 = 7'd77;
    n = cyc + 1;
    exp_mem_q.push_back('{cyc: n + 2, wr: 1'b0, addr: 31'd77, wdata: '0, chk_wd: 1'b0});
    exp_done_q.push_back('{cyc: n + 5, port: 1, rdata: mem_fn(31'd77), inv: 1'b0, tmo: 1'b0});
    wait_dones(1, 1'b0, 30);
    check_drained("reset_mid");
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    mem_lat = TMO + 4;
    @(negedge CLK);
    rd_2 = 1'b1; tag_2 = 24'd0; index_2 = 7'd9;
    n = cyc + 1;
    exp_mem_q.push_back('{cyc: n + 2, wr: 1'b0, addr: 31'd9, wdata: '0, chk_wd: 1'b0});
    exp_done_q.push_back('{cyc: n + 3 + TMO, port: 2, rdata: '0, inv: 1'b0, tmo: 1'b1});
    wait_dones(1, 1'b0, TMO + 20);
    repeat (10) @(negedge CLK);
    check_drained("timeout");
  endtask
`endif

  initial begin
    RST = 1'b0;
    rd_1 = 1'b0; wr_1 = 1'b0; tag_1 = '0; index_1 = '0; wdata_1 = '0;
    rd_2 = 1'b0; wr_2 = 1'b0; tag_2 = '0; index_2 = '0; wdata_2 = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_read_p1();
    test_both_write();
    test_alternate();
    test_invalid();
    test_no_abort();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
